// File: rtl/nco_i2s_tx.sv
// I2S transmitter for NCO sine samples. It sends a mono frame (the same word in the left and right slots), MSB first, with the standard one-bit delay.
// The newest sample is latched into a holding register and loaded once per frame; an underrun is flagged when no new sample has arrived since the last load.
module nco_i2s_tx #(
   parameter int unsigned mpr      = 14,
   parameter int unsigned sw       = 16,
   parameter int unsigned bclk_div = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           clken,
   input  logic [mpr-1:0] fsin_i,
   input  logic           in_valid,
   output logic           aud_bclk,
   output logic           aud_daclrck,
   output logic           aud_dacdat,
   output logic           sample_taken,
   output logic           underrun
);

   localparam int unsigned div_w  = (bclk_div > 1) ? $clog2(bclk_div) : 1;
   localparam int unsigned bcnt_w = $clog2(2 * sw);
   localparam int unsigned pad_w  = sw - mpr;

   logic [div_w-1:0]  div_cnt;
   logic [bcnt_w-1:0] bit_cnt;
   logic [mpr-1:0]    hold;
   logic [sw-1:0]     word;
   logic              fresh;
   logic              armed;

   logic              div_wrap_c;
   logic              fall_c;
   logic              capture_c;
   logic              load_c;
   logic [bcnt_w-1:0] bit_nxt_c;
   logic [bcnt_w-1:0] idx_c;
   logic [bcnt_w-1:0] bit_sel_c;
   logic [sw-1:0]     load_word_c;
   logic [sw-1:0]     shifted_c;
   logic              dat_c;
   logic              lrck_c;

   // Divider strobes, slot sequencing and the next serial bit
   always_comb begin
      div_wrap_c  = (div_cnt == div_w'(bclk_div - 1));
      fall_c      = div_wrap_c & aud_bclk;
      capture_c   = clken & in_valid;
      bit_nxt_c   = (bit_cnt == bcnt_w'(2 * sw - 1)) ? '0 : bit_cnt + bcnt_w'(1);
      load_c      = fall_c & (bit_cnt == bcnt_w'(2 * sw - 1));
      load_word_c = capture_c ? (sw'(fsin_i) << pad_w) : (sw'(hold) << pad_w);
      idx_c       = (bit_nxt_c >= bcnt_w'(sw)) ? bit_nxt_c - bcnt_w'(sw) : bit_nxt_c;
      bit_sel_c   = bcnt_w'(sw) - idx_c;
      shifted_c   = word >> bit_sel_c;
      lrck_c      = (bit_nxt_c >= bcnt_w'(sw));
      // idx 0 repeats the LSB of the slot just finished; both slots carry the same word
      dat_c       = (idx_c == '0) ? word[0] : shifted_c[0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt      <= '0;
         bit_cnt      <= '0;
         hold         <= '0;
         word         <= '0;
         fresh        <= 1'b0;
         armed        <= 1'b0;
         aud_bclk     <= 1'b0;
         aud_daclrck  <= 1'b0;
         aud_dacdat   <= 1'b0;
         sample_taken <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         div_cnt      <= div_wrap_c ? '0 : div_cnt + div_w'(1);
         sample_taken <= load_c;
         if (div_wrap_c) begin
            aud_bclk <= ~aud_bclk;
         end
         if (fall_c) begin
            bit_cnt     <= bit_nxt_c;
            aud_daclrck <= lrck_c;
            aud_dacdat  <= dat_c;
         end
         if (capture_c) begin
            hold  <= fsin_i;
            armed <= 1'b1;
         end
         // A capture coinciding with a load is consumed by that load
         if (load_c) begin
            word  <= load_word_c;
            fresh <= 1'b0;
         end else if (capture_c) begin
            fresh <= 1'b1;
         end
         if (load_c && !fresh && !capture_c && armed) begin
            underrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nco_i2s_tx.sv
// Testbench for nco_i2s_tx. A time-indexed reference model predicts every output on each cycle.
// Scenario tasks add directed checks on the slot bit patterns, on underrun, and on reset behaviour.
module tb_nco_i2s_tx;

   localparam int MPR   = 14;
   localparam int SW    = 16;
   localparam int D     = 4;
   localparam int FRAME = 4 * D * SW;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           clken;
   logic [MPR-1:0] fsin_i;
   logic           in_valid;
   logic           aud_bclk, aud_daclrck, aud_dacdat, sample_taken, underrun;
   logic [4:0]     act;

   int vectors     = 0;
   int miscompares = 0;

   nco_i2s_tx #(.mpr(MPR), .sw(SW), .bclk_div(D)) dut (
      .clk(clk), .reset_n(reset_n), .clken(clken), .fsin_i(fsin_i), .in_valid(in_valid),
      .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat),
      .sample_taken(sample_taken), .underrun(underrun)
   );

   assign act = {aud_bclk, aud_daclrck, aud_dacdat, sample_taken, underrun};

   always #5 clk = ~clk;

   // Reference model: t counts clk edges since reset release, and the frame words are kept per load.
   int             t;
   logic [SW-1:0]  m_cur, m_prev;
   logic [MPR-1:0] m_hold;
   bit             m_fresh, m_armed, m_under;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t = 0; m_cur = '0; m_prev = '0; m_hold = '0;
         m_fresh = 0; m_armed = 0; m_under = 0;
      end else begin
         t = t + 1;
         if (t % FRAME == 0) begin
            m_prev = m_cur;
            if (clken && in_valid) m_cur = SW'(fsin_i) << (SW - MPR);
            else begin
               if (!m_fresh && m_armed) m_under = 1;
               m_cur = SW'(m_hold) << (SW - MPR);
            end
            m_fresh = 0;
         end else if (clken && in_valid) begin
            m_fresh = 1;
         end
         if (clken && in_valid) begin
            m_hold  = fsin_i;
            m_armed = 1;
         end
      end
   end

   function automatic logic [4:0] exp_vec();
      int   m, bc, idx;
      logic b, lr, dat, st;
      m   = t / (2 * D);
      bc  = m % (2 * SW);
      idx = bc % SW;
      b   = ((t / D) % 2) == 1;
      lr  = bc >= SW;
      st  = (t > 0) && (t % FRAME == 0);
      dat = (idx == 0) ? ((bc == 0) ? m_prev[0] : m_cur[0]) : m_cur[SW - idx];
      return {b, lr, dat, st, m_under};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; clken = 1'b0; in_valid = 1'b0; fsin_i = '0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; clken = 1'b1; in_valid = 1'b1; fsin_i = MPR'($urandom);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         vectors++;
         if (act !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_state c=%0d got %b expected 00000", c, act);
         end
      end
      in_valid = 1'b0; clken = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic test_clken_off();
      logic saw_one = 1'b0;
      do_reset();
      clken = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clk);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL clken_off t=%0d got %b expected %b", t, act, exp_vec());
         end
         if (aud_dacdat) saw_one = 1'b1;
         fsin_i = MPR'($urandom);
      end
      vectors++;
      if (saw_one !== 1'b0 || underrun !== 1'b0) begin
         miscompares++;
         $display("FAIL clken_off_quiet got dat_seen=%b underrun=%b expected 0 0", saw_one, underrun);
      end
   endtask

   task automatic test_const(input logic [MPR-1:0] val, input logic [SW-1:0] slot_exp, input string name);
      int            pulses = 0;
      int            rises  = 0;
      int            rcnt   = -1;
      logic          bq     = 1'b0;
      logic [SW-1:0] left   = '0;
      logic [SW-1:0] right  = '0;
      do_reset();
      clken = 1'b1; in_valid = 1'b1; fsin_i = val;
      for (int c = 0; c < 4 * FRAME; c++) begin
         @(negedge clk);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL %s t=%0d got %b expected %b", name, t, act, exp_vec());
         end
         if (sample_taken) begin
            pulses++;
            if (rcnt < 0) rcnt = 0;
         end
         if (aud_bclk && !bq) begin
            rises++;
            if (rcnt >= 0) begin
               rcnt++;
               if (rcnt >= 2 && rcnt <= 17) left = {left[SW-2:0], aud_dacdat};
               else if (rcnt >= 18 && rcnt <= 33) right = {right[SW-2:0], aud_dacdat};
            end
         end
         bq = aud_bclk;
      end
      vectors++;
      if (pulses != 4) begin
         miscompares++;
         $display("FAIL %s_pulses got %0d expected 4", name, pulses);
      end
      vectors++;
      if (rises != 128) begin
         miscompares++;
         $display("FAIL %s_bclk_rises got %0d expected 128", name, rises);
      end
      vectors++;
      if (left !== slot_exp) begin
         miscompares++;
         $display("FAIL %s_left got %h expected %h", name, left, slot_exp);
      end
      vectors++;
      if (right !== slot_exp) begin
         miscompares++;
         $display("FAIL %s_right got %h expected %h", name, right, slot_exp);
      end
   endtask

   task automatic test_single_pulse();
      logic mid_under = 1'b1;
      do_reset();
      clken = 1'b1;
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clk);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL single_pulse t=%0d got %b expected %b", t, act, exp_vec());
         end
         if (t == FRAME + 40) mid_under = underrun;
         in_valid = (c == 10);
         fsin_i   = MPR'($urandom);
      end
      vectors++;
      if (mid_under !== 1'b0 || underrun !== 1'b1) begin
         miscompares++;
         $display("FAIL single_pulse_underrun got mid=%b end=%b expected 0 1", mid_under, underrun);
      end
   endtask

   task automatic test_coincident();
      logic [MPR-1:0] v;
      logic [SW-1:0]  left = '0;
      int             rcnt = -1;
      logic           bq   = 1'b0;
      v = MPR'($urandom) | MPR'(1);
      do_reset();
      clken = 1'b1;
      for (int c = 0; c < 2 * FRAME - 10; c++) begin
         @(negedge clk);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL coincident t=%0d got %b expected %b", t, act, exp_vec());
         end
         if (sample_taken && rcnt < 0) rcnt = 0;
         if (aud_bclk && !bq && rcnt >= 0) begin
            rcnt++;
            if (rcnt >= 2 && rcnt <= 17) left = {left[SW-2:0], aud_dacdat};
         end
         bq = aud_bclk;
         in_valid = (t == FRAME - 1);
         fsin_i   = in_valid ? v : MPR'($urandom);
      end
      vectors++;
      if (underrun !== 1'b0 || left !== (SW'(v) << (SW - MPR))) begin
         miscompares++;
         $display("FAIL coincident_load got word=%h underrun=%b expected %h 0", left, underrun, SW'(v) << (SW - MPR));
      end
   endtask

   task automatic test_midframe_reset();
      int first = -1;
      do_reset();
      clken = 1'b1; in_valid = 1'b1;
      for (int c = 0; c < FRAME + 199; c++) begin
         @(negedge clk);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL midreset_run t=%0d got %b expected %b", t, act, exp_vec());
         end
         fsin_i = MPR'($urandom) | MPR'(14'h1000);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if (act !== 5'b00000) begin
         miscompares++;
         $display("FAIL midreset_async got %b expected 00000", act);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL midreset_after t=%0d got %b expected %b", t, act, exp_vec());
         end
         if (aud_bclk && first < 0) first = k;
      end
      vectors++;
      if (first != 4) begin
         miscompares++;
         $display("FAIL midreset_first_rise got %0d expected 4", first);
      end
   endtask

   task automatic test_random();
      int density;
      do_reset();
      for (int f = 0; f < 12; f++) begin
         density = int'($urandom_range(0, 3));
         for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            vectors++;
            if (act !== exp_vec()) begin
               miscompares++;
               $display("FAIL random t=%0d got %b expected %b", t, act, exp_vec());
            end
            clken    = ($urandom_range(0, 7) != 0);
            in_valid = (density == 0) ? ($urandom_range(0, 999) == 0)
                                      : (int'($urandom_range(0, 3)) < density);
            fsin_i   = MPR'($urandom);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; clken = 1'b0; in_valid = 1'b0; fsin_i = '0;
      test_reset();
      test_clken_off();
      test_const(14'h1FFF, 16'h7FFC, "const_max");
      test_const(14'h2000, 16'h8000, "const_min");
      test_single_pulse();
      test_coincident();
      test_midframe_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
